// File: rtl/pred_pkg.sv
// Shared definitions for the multi-mode byte predictor.
// Holds byte and shift widths, the default block geometry, and the
// prediction-table entry type used by the top level and the byte selector.
package pred_pkg;

    localparam int BYTE_W        = 8;
    localparam int SHIFT_W       = 4;
    localparam int DEF_NUM_BYTES = 32;
    localparam int DEF_NUM_MODES = 4;
    // Base field is sized for the largest block (64 bytes) so the struct
    // stays parameter-free; unused upper bits are always zero.
    localparam int IDX_MAX_W     = 6;

    typedef struct packed {
        logic [IDX_MAX_W-1:0]      base;
        logic signed [SHIFT_W-1:0] shift;
    } tbl_entry_t;

endpackage

// File: rtl/pred_byte_sel.sv
// Per-byte predictor: picks one byte of the block by table base index and
// applies a signed shift (left for positive, logical right for negative).
// Ports:
//   blk  - full input block, index 0 is the most-significant byte
//   ent  - table entry (base index, two's complement shift)
//   pred - 8-bit prediction, truncated
module pred_byte_sel
    import pred_pkg::*;
#(
    parameter int NUM_BYTES = DEF_NUM_BYTES
) (
    input  logic [0:NUM_BYTES-1][BYTE_W-1:0] blk,
    input  tbl_entry_t                       ent,
    output logic [BYTE_W-1:0]                pred
);

    logic [BYTE_W-1:0]  sel;
    logic [SHIFT_W-1:0] mag;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (ent.base == IDX_MAX_W'(i)) sel = blk[i];
        end
        // -8 negates to 4'b1000 = 8 unsigned, and an 8-bit value shifted
        // right by 8 is zero, so that corner needs no special case.
        mag = ent.shift[SHIFT_W-1] ? SHIFT_W'(-ent.shift) : SHIFT_W'(ent.shift);
        if (ent.shift[SHIFT_W-1]) pred = sel >> mag;
        else                      pred = sel << mag;
    end

endmodule

// File: rtl/multi_mode_predictor.sv
// Multi-mode byte predictor. Each accepted block is predicted with one of
// NUM_MODES run-time tables: every byte j gets a prediction from
// byte[base[m][j]] with a signed shift; the root byte is split out and the
// remaining bytes/predictions are compacted in ascending index order.
// Two pipeline stages (S1: input register, S2: result register) with
// independent valid/ready flow control.
// Optional feature macro: PRED_RESIDUE_EN adds out_resid = out_data ^ out_pred.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   cfg_*               - table write port; accepted only while fully idle
//   in_valid/ready/data/mode   - input block handshake
//   out_valid/ready/mode/root/data/pred (/resid) - output block handshake
module multi_mode_predictor
    import pred_pkg::*;
#(
    parameter  int NUM_BYTES = DEF_NUM_BYTES,
    parameter  int NUM_MODES = DEF_NUM_MODES,
    parameter  int ROOT_RST  = 21,
    localparam int BW = $clog2(NUM_BYTES),
    localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
    localparam int OW = BYTE_W * (NUM_BYTES - 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_we,
    output logic                        cfg_ready,
    input  logic [MW-1:0]               cfg_mode,
    input  logic                        cfg_sel_root,
    input  logic [BW-1:0]               cfg_byte,
    input  logic [BW-1:0]               cfg_base,
    input  logic [SHIFT_W-1:0]          cfg_shift,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BYTE_W*NUM_BYTES-1:0] in_data,
    input  logic [MW-1:0]               in_mode,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [MW-1:0]               out_mode,
    output logic [BYTE_W-1:0]           out_root,
    output logic [OW-1:0]               out_data,
    output logic [OW-1:0]               out_pred
`ifdef PRED_RESIDUE_EN
    ,
    output logic [OW-1:0]               out_resid
`endif
);

    typedef logic [0:NUM_BYTES-1][BYTE_W-1:0] blk_t;
    typedef logic [0:NUM_BYTES-2][BYTE_W-1:0] slot_t;

    // ---------------- prediction tables ----------------
    logic [BW-1:0] root_tbl [NUM_MODES];
    tbl_entry_t    ent_tbl  [NUM_MODES][NUM_BYTES];
    logic          cfg_hit;

    // vld_pipe[1] = S1 occupied, vld_pipe[2] = S2 occupied
    logic [2:1]    vld_pipe;
    logic          s2_en;

    // Tables only change with the pipe empty and no block offered, so a
    // block never sees a half-updated table.
    assign cfg_ready = !vld_pipe[1] && !vld_pipe[2] && !in_valid;
    assign cfg_hit   = cfg_we && cfg_ready
                    && (int'(cfg_mode) < NUM_MODES)
                    && (int'(cfg_base) < NUM_BYTES)
                    && (int'(cfg_byte) < NUM_BYTES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < NUM_MODES; m++) begin
                root_tbl[m] <= BW'(ROOT_RST);
                for (int j = 0; j < NUM_BYTES; j++)
                    ent_tbl[m][j] <= '{base: IDX_MAX_W'(ROOT_RST), shift: '0};
            end
        end else if (cfg_hit) begin
            if (cfg_sel_root) root_tbl[cfg_mode] <= cfg_base;
            else ent_tbl[cfg_mode][cfg_byte] <= '{base: IDX_MAX_W'(cfg_base),
                                                 shift: cfg_shift};
        end
    end

    // ---------------- S1: input register ----------------
    blk_t          s1_blk;
    logic [MW-1:0] s1_mode;
    logic [MW-1:0] in_mode_ok;

    assign s2_en      = !vld_pipe[2] || out_ready;
    assign in_ready   = !vld_pipe[1] || s2_en;
    assign in_mode_ok = (int'(in_mode) < NUM_MODES) ? in_mode : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[1] <= 1'b0;
            s1_blk      <= '0;
            s1_mode     <= '0;
        end else if (in_ready) begin
            vld_pipe[1] <= in_valid;
            if (in_valid) begin
                s1_blk  <= in_data;
                s1_mode <= in_mode_ok;
            end
        end
    end

    // ---------------- prediction + compaction ----------------
    logic [0:NUM_BYTES-1][BYTE_W-1:0] pred_all;

    for (genvar j = 0; j < NUM_BYTES; j++) begin : g_sel
        pred_byte_sel #(.NUM_BYTES(NUM_BYTES)) u_sel (
            .blk  (s1_blk),
            .ent  (ent_tbl[s1_mode][j]),
            .pred (pred_all[j])
        );
    end

    logic [BW-1:0]     root_idx;
    logic [BYTE_W-1:0] c_root;
    slot_t             c_data;
    slot_t             c_pred;

    // Slot k holds index k below the root and index k+1 at/above it.
    always_comb begin
        root_idx = root_tbl[s1_mode];
        c_root   = '0;
        c_data   = '0;
        c_pred   = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (root_idx == BW'(i)) c_root = s1_blk[i];
        end
        for (int k = 0; k < NUM_BYTES - 1; k++) begin
            if (BW'(k) < root_idx) begin
                c_data[k] = s1_blk[k];
                c_pred[k] = pred_all[k];
            end else begin
                c_data[k] = s1_blk[k+1];
                c_pred[k] = pred_all[k+1];
            end
        end
    end

    // ---------------- S2: output register ----------------
    slot_t s2_data;
    slot_t s2_pred;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[2] <= 1'b0;
            out_mode    <= '0;
            out_root    <= '0;
            s2_data     <= '0;
            s2_pred     <= '0;
        end else if (s2_en) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
                out_mode <= s1_mode;
                out_root <= c_root;
                s2_data  <= c_data;
                s2_pred  <= c_pred;
            end
        end
    end

    assign out_valid = vld_pipe[2];
    assign out_data  = s2_data;
    assign out_pred  = s2_pred;

`ifdef PRED_RESIDUE_EN
    slot_t s2_resid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       s2_resid <= '0;
        else if (s2_en && vld_pipe[1])    s2_resid <= c_data ^ c_pred;
    end

    assign out_resid = s2_resid;
`endif

endmodule

// File: tb/tb_multi_mode_predictor.sv
// Directed bench for multi_mode_predictor (NUM_BYTES=32, NUM_MODES=3 so an
// out-of-range mode can be driven). Expected values are hand constants plus
// a small table model updated only from the writes the bench issues.
module tb_multi_mode_predictor;

    logic         clk, rst_n;
    logic         cfg_we, cfg_ready, cfg_sel_root;
    logic [1:0]   cfg_mode, in_mode, out_mode;
    logic [4:0]   cfg_byte, cfg_base;
    logic [3:0]   cfg_shift;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [255:0] in_data;
    logic [7:0]   out_root;
    logic [247:0] out_data, out_pred;
`ifdef PRED_RESIDUE_EN
    logic [247:0] out_resid;
`endif

    multi_mode_predictor #(.NUM_BYTES(32), .NUM_MODES(3), .ROOT_RST(21)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
        .cfg_sel_root(cfg_sel_root), .cfg_byte(cfg_byte), .cfg_base(cfg_base),
        .cfg_shift(cfg_shift),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
        .out_root(out_root), .out_data(out_data), .out_pred(out_pred)
`ifdef PRED_RESIDUE_EN
        , .out_resid(out_resid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- table model ----------------
    int mroot [3];
    int mbase [3][32];
    int msh   [3][32];

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            mroot[m] = 21;
            for (int j = 0; j < 32; j++) begin
                mbase[m][j] = 21;
                msh[m][j]   = 0;
            end
        end
    endtask

    function automatic logic [7:0] bget(input logic [255:0] b, input int i);
        return b[255-8*i -: 8];
    endfunction

    function automatic logic [7:0] pshift(input logic [7:0] v, input int s);
        int x;
        x = int'(v);
        if (s >= 8 || s <= -8) return 8'h00;
        if (s > 0) return 8'((x << s) & 255);
        if (s < 0) return 8'(x >> (-s));
        return v;
    endfunction

    function automatic logic [247:0] exp_data(input logic [255:0] b, input int m);
        logic [247:0] r;
        int idx;
        r = '0;
        for (int k = 0; k < 31; k++) begin
            idx = (k < mroot[m]) ? k : k + 1;
            r[247-8*k -: 8] = bget(b, idx);
        end
        return r;
    endfunction

    function automatic logic [247:0] exp_pred(input logic [255:0] b, input int m);
        logic [247:0] r;
        int idx;
        r = '0;
        for (int k = 0; k < 31; k++) begin
            idx = (k < mroot[m]) ? k : k + 1;
            r[247-8*k -: 8] = pshift(bget(b, mbase[m][idx]), msh[m][idx]);
        end
        return r;
    endfunction

    function automatic logic [255:0] mkblk(input int seed);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[255-8*i -: 8] = 8'((seed + 3*i) & 255);
        return r;
    endfunction

    function automatic logic [255:0] ramp(input int base);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[255-8*i -: 8] = 8'((base + i) & 255);
        return r;
    endfunction

    task automatic check_out(input logic [255:0] b, input int m);
        int mm;
        mm = (m < 3) ? m : 0;
        chk("out_root", out_root, bget(b, mroot[mm]));
        chk("out_data", out_data, exp_data(b, mm));
        chk("out_pred", out_pred, exp_pred(b, mm));
        chk("out_mode", out_mode, mm);
`ifdef PRED_RESIDUE_EN
        chk("out_resid", out_resid, exp_data(b, mm) ^ exp_pred(b, mm));
`endif
    endtask

    // Table write; model follows only when the bench expects acceptance.
    task automatic cfg_wr(input int m, input bit root_sel, input int byt, input int base,
                          input int sh, input bit expect_ok);
        @(negedge clk);
        cfg_we = 1'b1; cfg_mode = 2'(m); cfg_sel_root = root_sel;
        cfg_byte = 5'(byt); cfg_base = 5'(base); cfg_shift = 4'(sh);
        #1 chk("cfg_ready", cfg_ready, expect_ok);
        @(posedge clk);
        if (expect_ok) begin
            if (root_sel) mroot[m] = base;
            else begin
                mbase[m][byt] = base;
                msh[m][byt]   = sh;
            end
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Single block, out_ready high: checks latency then leaves the result
    // on the outputs at a falling edge for the caller to inspect.
    task automatic one_block(input logic [255:0] b, input int m);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = b; in_mode = 2'(m);
        #1 chk("in_ready", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("lat_cycle1", out_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_cycle2", out_valid, 1'b1);
        check_out(b, m);
    endtask

    task automatic run_stream(input int n, input bit bp, input int m0, input int m1,
                              input int seed);
        logic [255:0] blks [16];
        int           modes [16];
        int           sent, rcvd, cyc;
        bit           held;
        logic [7:0]   h_root;
        logic [247:0] h_data, h_pred;
        sent = 0; rcvd = 0; cyc = 0; held = 0;
        h_root = '0; h_data = '0; h_pred = '0;
        for (int i = 0; i < n; i++) begin
            blks[i]  = mkblk(seed + 7*i);
            modes[i] = (i % 2 == 0) ? m0 : m1;
        end
        while (rcvd < n && cyc < 200) begin
            @(negedge clk);
            out_ready = bp ? (cyc % 2 == 0) : 1'b1;
            if (sent < n) begin
                in_valid = 1'b1; in_data = blks[sent]; in_mode = 2'(modes[sent]);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (held) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_root", out_root, h_root);
                chk("stall_data", out_data, h_data);
                chk("stall_pred", out_pred, h_pred);
            end
            held = out_valid && !out_ready;
            h_root = out_root; h_data = out_data; h_pred = out_pred;
            if (out_valid && out_ready) begin
                if (rcvd < sent) check_out(blks[rcvd], modes[rcvd]);
                else chk("stream_spurious", 1'b1, 1'b0);
                rcvd++;
            end
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_count", rcvd, n);
        chk("stream_sent", sent, n);
    endtask

    initial begin
        logic [255:0] b;
        logic [247:0] e;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_mode = '0; cfg_sel_root = 1'b0;
        cfg_byte = '0; cfg_base = '0; cfg_shift = '0;
        in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b1;
        model_reset();

        // reset state
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_cfg_ready", cfg_ready, 1'b1);
        chk("rst_out_root", out_root, 8'h00);
        chk("rst_out_data", out_data, 248'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // defaults: root 21, every prediction = byte 21
        b = ramp(0);
        one_block(b, 0);
        chk("def_root", out_root, 8'h15);
        chk("def_pred", out_pred, {31{8'h15}});
        e = '0;
        for (int k = 0; k < 31; k++) e[247-8*k -: 8] = 8'((k < 21) ? k : k + 1);
        chk("def_data", out_data, e);
        chk("def_slot21", out_data[247-8*21 -: 8], 8'h16);

        // shift rules on mode 1
        cfg_wr(1, 0, 3, 5, 1, 1);
        cfg_wr(1, 0, 4, 5, -8, 1);
        cfg_wr(1, 0, 6, 5, -1, 1);
        cfg_wr(1, 0, 7, 5, 7, 1);
        b = ramp(0);
        b[255-8*5 -: 8] = 8'h81;
        one_block(b, 1);
        chk("sh_pos1", out_pred[247-8*3 -: 8], 8'h02);
        chk("sh_neg8", out_pred[247-8*4 -: 8], 8'h00);
        chk("sh_neg1", out_pred[247-8*6 -: 8], 8'h40);
        chk("sh_pos7", out_pred[247-8*7 -: 8], 8'h80);
        chk("sh_zero", out_pred[247-8*0 -: 8], 8'h15);
        chk("sh_data5", out_data[247-8*5 -: 8], 8'h81);

        // root change on mode 2
        cfg_wr(2, 1, 0, 0, 0, 1);
        b = ramp(8'hA0);
        one_block(b, 2);
        chk("root0_root", out_root, 8'hA0);
        chk("root0_slot0", out_data[247 -: 8], 8'hA1);
        chk("root0_last", out_data[7:0], 8'hBF);

        // out-of-range mode behaves as mode 0
        b = ramp(0);
        one_block(b, 3);
        chk("mode3_root", out_root, 8'h15);

        // interleaved modes back to back, then backpressure
        run_stream(4, 1'b0, 0, 2, 17);
        run_stream(10, 1'b1, 1, 0, 90);

        // config gating while a block is in flight
        @(negedge clk);
        in_valid = 1'b1; in_data = ramp(0); in_mode = 2'd0;
        cfg_we = 1'b1; cfg_mode = 2'd0; cfg_sel_root = 1'b1;
        cfg_byte = 5'd0; cfg_base = 5'd0; cfg_shift = 4'd0;
        #1 chk("gate_in_valid", cfg_ready, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("gate_s1", cfg_ready, 1'b0);
        @(negedge clk);
        chk("gate_s2", cfg_ready, 1'b0);
        chk("gate_inflight_root", out_root, 8'h15);
        cfg_we = 1'b0;
        @(negedge clk);
        one_block(ramp(0), 0);
        chk("gate_unchanged", out_root, 8'h15);
        cfg_wr(0, 1, 0, 0, 0, 1);
        one_block(ramp(0), 0);
        chk("gate_retry", out_root, 8'h00);

        // reset with both stages full
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = ramp(3); in_mode = 2'd2;
        @(negedge clk);
        in_data = ramp(9);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("full_out_valid", out_valid, 1'b1);
        chk("full_in_ready", in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_root", out_root, 8'h00);
        chk("midrst_data", out_data, 248'h0);
        chk("midrst_in_ready", in_ready, 1'b1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        b = ramp(0);
        b[255-8*5 -: 8] = 8'h81;
        one_block(b, 2);
        chk("post_rst_root", out_root, 8'h15);
        one_block(b, 1);
        chk("post_rst_pred", out_pred, {31{8'h15}});

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
